// File: rtl/lsu_axi4_master.sv
// ---------------------------------------------------------------------------
// lsu_axi4_master
//
// Single-outstanding AXI4 initiator. Converts the LSU request/response port
// into single-beat AXI4 read or write transactions, one at a time, towards
// the system crossbar (timer, UART and other memory-mapped responders).
//
// Parameters:
//   AXI_ID          ID driven on arid/awid and expected back on rid/bid
//   TIMEOUT_CYCLES  response watchdog limit (only with LSU_AXI_TIMEOUT_EN)
//
// Optional feature (compile-time macro LSU_AXI_TIMEOUT_EN):
//   When defined, a watchdog aborts any transaction that stays outside IDLE
//   for TIMEOUT_CYCLES cycles. The aborted transaction completes with
//   resp_err=1 and resp_rdata=0. When undefined, the block waits forever.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready             LSU request handshake
//   req_wen                         1=write, 0=read
//   req_addr/req_wdata/req_wstrb    byte address, lane-aligned data, strobes
//   req_size                        AXI size code (0=B, 1=H, 2=W)
//   resp_valid                      one-cycle completion pulse
//   resp_rdata/resp_err             read data (0 for writes), error flag;
//                                   held until the next resp_valid
//   ar*/r*                          AXI4 read address / read data channels
//   aw*/w*/b*                       AXI4 write address / data / resp channels
// ---------------------------------------------------------------------------
module lsu_axi4_master #(
    parameter logic [3:0]  AXI_ID         = 4'd0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,

    // LSU request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_size,

    // LSU response side
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    // AXI4 read address channel
    output logic [31:0] araddr,
    output logic        arvalid,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        arready,

    // AXI4 read data channel
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    input  logic        rlast,
    input  logic [3:0]  rid,
    output logic        rready,

    // AXI4 write address channel
    output logic [31:0] awaddr,
    output logic        awvalid,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    input  logic        awready,

    // AXI4 write data channel
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    output logic        wlast,
    input  logic        wready,

    // AXI4 write response channel
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    input  logic [3:0]  bid,
    output logic        bready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WREQ  = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  size_q;

    logic        aw_done;
    logic        w_done;

    logic        accept;
    logic        ar_hs;
    logic        r_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        write_addr_ok;
    logic        write_data_ok;
    logic        timeout;

    // Channel valids/readies are pure functions of the registered state, so
    // a reset drops all of them on the very next cycle.
    assign req_ready = (state == IDLE);
    assign arvalid   = (state == RADDR);
    assign rready    = (state == RDATA);
    assign awvalid   = (state == WREQ) && !aw_done;
    assign wvalid    = (state == WREQ) && !w_done;
    assign wlast     = wvalid;
    assign bready    = (state == WRESP);

    // Fixed single-beat INCR burst fields
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign arsize  = size_q;
    assign awsize  = size_q;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;

    assign accept = req_valid && req_ready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rready && rvalid;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bready && bvalid;

    // A write channel counts as finished if it completed earlier or is
    // completing this cycle; both may finish in the same cycle.
    assign write_addr_ok = aw_done || aw_hs;
    assign write_data_ok = w_done || w_hs;

`ifdef LSU_AXI_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Watchdog: restarts on every accepted request and counts each cycle
    // spent outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= 32'd0;
        end else if (accept) begin
            to_cnt <= 32'd0;
        end else if (state != IDLE) begin
            to_cnt <= to_cnt + 32'd1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th non-IDLE cycle. A genuine response
    // arriving in that same cycle wins over the abort.
    assign timeout = (state != IDLE) && (to_cnt == (TIMEOUT_CYCLES - 1)) &&
                     !r_hs && !b_hs;
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    // Keeps the watchdog parameter referenced when the feature is compiled out.
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state logic for the transaction FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_wen ? WREQ : RADDR;
                end
            end
            RADDR: begin
                if (ar_hs) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    state_nxt = IDLE;
                end
            end
            WREQ: begin
                if (write_addr_ok && write_data_ok) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (timeout) begin
            state_nxt = IDLE;
        end
    end

    // State register and write-channel completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_done <= 1'b1;
                end
                if (w_hs) begin
                    w_done <= 1'b1;
                end
            end
        end
    end

    // Request capture; the AXI address/data outputs hold these values stable
    // for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            size_q  <= 3'd0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            size_q  <= req_size;
        end
    end

    // Completion pulse, registered so it coincides with the first IDLE cycle
    // after the R/B handshake. Data and error are held until the next pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (r_hs) begin
                resp_valid <= 1'b1;
                resp_rdata <= rdata;
                resp_err   <= (rresp != 2'b00) || (rid != AXI_ID) || !rlast;
            end else if (b_hs) begin
                resp_valid <= 1'b1;
                resp_rdata <= 32'd0;
                resp_err   <= (bresp != 2'b00) || (bid != AXI_ID);
            end else if (timeout) begin
                resp_valid <= 1'b1;
                resp_rdata <= 32'd0;
                resp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi4_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_axi4_master
//
// Directed self-checking bench for lsu_axi4_master. The slave side is driven
// by hand, step by step. Inputs change and outputs are sampled 1 time unit
// after each rising clock edge. With LSU_AXI_TIMEOUT_EN defined the DUT is
// built with TIMEOUT_CYCLES=16 and the watchdog abort is also exercised.
// ---------------------------------------------------------------------------
module tb_lsu_axi4_master;

`ifdef LSU_AXI_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_size;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic [3:0]  rid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic [3:0]  bid;
    logic        bready;

    int errors = 0;
    int checks = 0;

    lsu_axi4_master #(
        .AXI_ID         (4'd0),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arid       (arid),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .rid        (rid),
        .rready     (rready),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awid       (awid),
        .awlen      (awlen),
        .awsize     (awsize),
        .awburst    (awburst),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wlast      (wlast),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bid        (bid),
        .bready     (bready)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the LSU request port
    task automatic applyStimulus(input logic v, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] strb, input logic [2:0] size);
        req_valid = v;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = strb;
        req_size  = size;
    endtask

    // One comparison: counts it, and on mismatch counts the failure and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h",
                   tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rid = 4'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0; bid = 4'd0;

        // ---- reset state ----
        tick();
        tick();
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_valids", {26'd0, arvalid, awvalid, wvalid, rready, bready, resp_valid}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        // ---- stray B response while idle is ignored ----
        bvalid = 1'b1;
        tick();
        checkOutput("idle_bready", {31'd0, bready}, 32'd0);
        bvalid = 1'b0;
        tick();
        checkOutput("idle_no_resp", {31'd0, resp_valid}, 32'd0);

        // ---- read 0x02000048: accept c0, AR c1, R c2, resp c3 ----
        applyStimulus(1'b1, 1'b0, 32'h0200_0048, 32'd0, 4'hF, 3'd2);
        checkOutput("rd_req_ready_c0", {31'd0, req_ready}, 32'd1);
        tick();                                   // c1
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        checkOutput("rd_arvalid_c1", {31'd0, arvalid}, 32'd1);
        checkOutput("rd_araddr", araddr, 32'h0200_0048);
        checkOutput("rd_ar_fields", {12'd0, arid, arlen, 1'b0, arsize, 2'b00, arburst},
                    {12'd0, 4'd0, 8'd0, 1'b0, 3'd2, 2'b00, 2'b01});
        checkOutput("rd_req_ready_busy", {31'd0, req_ready}, 32'd0);
        arready = 1'b1;
        tick();                                   // c2
        arready = 1'b0;
        checkOutput("rd_rdata_state", {30'd0, arvalid, rready}, 32'd1);
        rvalid = 1'b1; rdata = 32'h0000_1234; rresp = 2'd0; rlast = 1'b1; rid = 4'd0;
        tick();                                   // c3
        rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0;
        checkOutput("rd_resp_valid_c3", {31'd0, resp_valid}, 32'd1);
        checkOutput("rd_resp_rdata", resp_rdata, 32'h0000_1234);
        checkOutput("rd_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("rd_idle_again", {30'd0, req_ready, rready}, 32'd2);
        tick();                                   // c4
        checkOutput("rd_pulse_one_cycle", {31'd0, resp_valid}, 32'd0);
        checkOutput("rd_rdata_held", resp_rdata, 32'h0000_1234);

        // ---- write 0x10000000: wready immediate, awready 2 cycles late ----
        applyStimulus(1'b1, 1'b1, 32'h1000_0000, 32'h0000_00A5, 4'b0001, 3'd0);
        tick();                                   // c1
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        checkOutput("wr_both_valid_c1", {29'd0, awvalid, wvalid, wlast}, 32'd7);
        checkOutput("wr_awaddr", awaddr, 32'h1000_0000);
        checkOutput("wr_wdata", wdata, 32'h0000_00A5);
        checkOutput("wr_wstrb_awsize", {25'd0, wstrb, awsize}, {25'd0, 4'b0001, 3'd0});
        checkOutput("wr_aw_fields", {18'd0, awid, awlen, awburst}, {18'd0, 4'd0, 8'd0, 2'b01});
        wready = 1'b1;
        tick();                                   // c2
        wready = 1'b0;
        checkOutput("wr_c2_aw_only", {29'd0, awvalid, wvalid, wlast}, 32'd4);
        tick();                                   // c3
        checkOutput("wr_c3_aw_hold", {30'd0, awvalid, bready}, 32'd2);
        awready = 1'b1;
        tick();                                   // c4
        awready = 1'b0;
        checkOutput("wr_c4_wresp", {29'd0, awvalid, wvalid, bready}, 32'd1);
        bvalid = 1'b1; bresp = 2'd0; bid = 4'd0;
        tick();                                   // c5
        bvalid = 1'b0;
        checkOutput("wr_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("wr_resp_err", {31'd0, resp_err}, 32'd0);
        checkOutput("wr_resp_rdata_zero", resp_rdata, 32'd0);
        tick();

        // ---- read with SLVERR ----
        applyStimulus(1'b1, 1'b0, 32'h0200_0000, 32'd0, 4'hF, 3'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rresp = 2'd0; rlast = 1'b0;
        checkOutput("rderr_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("rderr_resp_err", {31'd0, resp_err}, 32'd1);
        checkOutput("rderr_rdata", resp_rdata, 32'hDEAD_BEEF);
        tick();

        // ---- write, AW+W in the same cycle, wrong bid ----
        applyStimulus(1'b1, 1'b1, 32'h1000_0004, 32'h0000_5A00, 4'b0010, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        awready = 1'b1; wready = 1'b1; rvalid = 1'b1;
        checkOutput("wrerr_stray_rready", {31'd0, rready}, 32'd0);
        tick();
        awready = 1'b0; wready = 1'b0; rvalid = 1'b0;
        checkOutput("wrerr_both_done", {29'd0, awvalid, wvalid, bready}, 32'd1);
        bvalid = 1'b1; bresp = 2'd0; bid = 4'h3;
        tick();
        bvalid = 1'b0; bid = 4'd0;
        checkOutput("wrerr_resp_valid", {31'd0, resp_valid}, 32'd1);
        checkOutput("wrerr_resp_err", {31'd0, resp_err}, 32'd1);
        tick();

        // ---- back-to-back reads, req_valid held high ----
        applyStimulus(1'b1, 1'b0, 32'h0200_0100, 32'd0, 4'hF, 3'd2);
        tick();                                   // c1
        arready = 1'b1;
        tick();                                   // c2
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0001; rlast = 1'b1;
        tick();                                   // c3
        rvalid = 1'b0; rlast = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0200_0104, 32'd0, 4'hF, 3'd1);
        checkOutput("b2b_first_resp", {30'd0, resp_valid, req_ready}, 32'd3);
        checkOutput("b2b_first_rdata", resp_rdata, 32'h0000_0001);
        tick();                                   // c4: second read already issued
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        checkOutput("b2b_second_arvalid", {31'd0, arvalid}, 32'd1);
        checkOutput("b2b_second_araddr", araddr, 32'h0200_0104);
        checkOutput("b2b_second_arsize", {29'd0, arsize}, 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0002; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        checkOutput("b2b_second_resp", {31'd0, resp_valid}, 32'd1);
        checkOutput("b2b_second_rdata", resp_rdata, 32'h0000_0002);
        tick();

        // ---- reset while in RDATA, with rvalid present ----
        applyStimulus(1'b1, 1'b0, 32'h0200_0200, 32'd0, 4'hF, 3'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checkOutput("rstmid_in_rdata", {31'd0, rready}, 32'd1);
        rst = 1'b1;
        rvalid = 1'b1; rdata = 32'h0000_BEEF; rlast = 1'b1;
        tick();
        rst = 1'b0;
        rvalid = 1'b0; rlast = 1'b0;
        checkOutput("rstmid_outputs", {28'd0, arvalid, rready, resp_valid, req_ready}, 32'd1);
        checkOutput("rstmid_rdata_cleared", resp_rdata, 32'd0);
        tick();
        checkOutput("rstmid_no_late_resp", {31'd0, resp_valid}, 32'd0);

`ifdef LSU_AXI_TIMEOUT_EN
        // ---- watchdog: arready never asserted ----
        applyStimulus(1'b1, 1'b0, 32'h0300_0000, 32'd0, 4'hF, 3'd2);
        tick();                                   // c1
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 3'd0);
        for (int i = 2; i <= 16; i++) begin
            tick();                               // c2..c16
        end
        checkOutput("to_still_waiting_c16", {30'd0, arvalid, resp_valid}, 32'd2);
        tick();                                   // c17
        checkOutput("to_resp_c17", {29'd0, resp_valid, resp_err, arvalid}, 32'd6);
        checkOutput("to_rdata_zero", resp_rdata, 32'd0);
        checkOutput("to_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_axi4_master.md
Name: lsu_axi4_master

Overview:
- Single-outstanding AXI4 initiator that turns the LSU's simple request/response port into single-beat AXI4 read or write bursts.
- Sits between the LSU and the system crossbar; drives memory-mapped responders such as the timer and UART.
- Exactly one transaction is in flight at a time; no bursts, no reordering.

Parameters:
AXI_ID, 4'd0, value driven on arid/awid and expected on rid/bid
TIMEOUT_CYCLES, 1024, response watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  LSU request valid
req_ready  out  1  block can accept a request
req_wen  in  1  1=write, 0=read
req_addr  in  32  byte address
req_wdata  in  32  write data, lane-aligned
req_wstrb  in  4  write byte strobes
req_size  in  3  AXI size code (0=B, 1=H, 2=W)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  read data (0 for writes)
resp_err  out  1  response error
araddr/arvalid/arid/arlen/arsize/arburst  out  32/1/4/8/3/2  AR channel
arready  in  1  AR ready
rdata/rresp/rvalid/rlast/rid  in  32/2/1/1/4  R channel
rready  out  1  R ready
awaddr/awvalid/awid/awlen/awsize/awburst  out  32/1/4/8/3/2  AW channel
awready  in  1  AW ready
wdata/wstrb/wvalid/wlast  out  32/4/1/1  W channel
wready  in  1  W ready
bresp/bvalid/bid  in  2/1/4  B channel
bready  out  1  B ready

Behaviour:
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- Reset: state IDLE; arvalid, awvalid, wvalid, rready, bready, resp_valid and resp_err all 0; resp_rdata 0.
- req_ready is 1 only in IDLE.
- Accept occurs when req_valid && req_ready. On accept, addr, wdata, wstrb and size are registered.
  - Read: go to RADDR.
  - Write: go to WREQ.
- Fixed AXI fields: arlen=awlen=0, arburst=awburst=2'b01, arsize/awsize=registered size, ar/awid=AXI_ID, wlast=wvalid.
- RADDR: arvalid=1, held with araddr stable until arready; then go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata and go to IDLE.
  - resp_err = (rresp!=0) || (rid!=AXI_ID) || !rlast.
- WREQ: awvalid and wvalid are both asserted in the first WREQ cycle.
  - Each drops independently after its own handshake; internal aw_done/w_done flags track this.
  - Both handshakes in the same cycle is legal.
  - Go to WRESP once both are done.
- WRESP: bready=1. On bvalid, go to IDLE.
  - resp_err = (bresp!=0) || (bid!=AXI_ID).
- resp_valid is a registered 1-cycle pulse, asserted the cycle after the R/B handshake, coinciding with the first IDLE cycle.
  - A new request may be accepted in that same cycle.
  - resp_rdata and resp_err stay valid until the next resp_valid.
- Latency: with a slave that has arready=1 and rvalid the cycle after the AR handshake, a read accepted at cycle 0 gives arvalid at cycle 1, rvalid at cycle 2 and resp_valid at cycle 3.
- Responses while not waiting for them (rvalid outside RDATA, bvalid outside WRESP) are ignored: rready/bready stay 0.
- Reset mid-transaction: all valids drop immediately, no resp_valid is produced, FSM returns to IDLE.

Optional Feature:
- Macro LSU_AXI_TIMEOUT_EN.
- When defined: a counter clears on entry to RADDR/WREQ and increments every non-IDLE cycle. When it reaches TIMEOUT_CYCLES:
  - all valid/ready outputs are dropped;
  - the FSM returns to IDLE;
  - resp_valid pulses with resp_err=1 and resp_rdata=0.
- When not defined: no counter; the block waits indefinitely.

Test Plan:
- Read 0x02000048: arready=1, rdata=0x1234 with rresp=0 and rlast=1 one cycle after AR -> resp_valid at cycle 3, resp_rdata=0x1234, resp_err=0.
- Write 0x10000000, wdata=0xA5, wstrb=0001: awready late by 2 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles; bvalid with bresp=0 -> resp_valid, resp_err=0.
- Read with rresp=2'b10, then a write with bid=4'h3 -> resp_err=1 both times.
- Back-to-back reads: req_valid held high -> second accept in the same cycle as the first resp_valid, no idle gap.
- rst asserted while in RDATA -> next cycle arvalid=rready=resp_valid=0, req_ready=1.
- With LSU_AXI_TIMEOUT_EN and TIMEOUT_CYCLES=16: arready held 0 -> resp_valid with resp_err=1 after 16 cycles, arvalid=0.
